fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer. Owns the architectural fetch PC, drives the instruction bus
//  (one outstanding request), and hands each fetched instruction to decode over a
//  valid/ready handshake. Accepts PC redirects from branch/jump resolution and discards
//  stale bus responses, so decode never sees a wrong-path instruction.
// PARAMETERS
//  RESET_PC  64'h8000_0000  first fetch address after reset
//  INSTR_W   32             instruction width
// PORTS
//  clk            in   1   clock, all state on posedge
//  resetn         in   1   asynchronous reset, active-low
//  ireq_valid     out  1   ibus request; held high until iresp_data_ok
//  ireq_addr      out  64  request address; stable while ireq_valid=1
//  iresp_data_ok  in   1   response data valid this cycle (completes request)
//  iresp_data     in   32  instruction returned by ibus
//  redirect_valid in   1   branch/jump resolved taken: restart fetch at redirect_pc
//  redirect_pc    in   64  redirect target
//  f_valid        out  1   instruction for decode valid
//  f_ready        in   1   decode accepts (0 = stall)
//  f_instr        out  32  fetched instruction (0 when f_exc)
//  f_pc           out  64  PC of f_instr
//  f_exc          out  1   instruction-address-misaligned flag for f_pc
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, pc=RESET_PC, f_valid=0, f_instr=0, f_pc=0,
//   f_exc=0, ireq_valid=0. IDLE -> REQ unconditionally on the first clock edge.
//  States: IDLE, REQ, DROP, FULL. ireq_valid=1 in REQ and DROP only; ireq_addr=pc in
//   REQ, ireq_addr=drop_addr (address of outstanding request) in DROP.
//  REQ:  data_ok & !redirect -> FULL; f_instr<=iresp_data, f_pc<=pc, f_exc<=0.
//        redirect & !data_ok -> DROP; drop_addr<=pc, pc<=redirect_pc.
//        redirect & data_ok  -> REQ; data discarded, pc<=redirect_pc (new req next cycle).
//  DROP: data_ok -> REQ, data discarded. Further redirect -> pc<=redirect_pc (latest
//        wins); stays DROP unless data_ok the same cycle (then REQ).
//  FULL: f_valid=1; outputs stable while f_ready=0.
//        redirect (priority over f_ready) -> REQ, pc<=redirect_pc, f_valid<=0.
//        f_ready & !redirect -> REQ, pc<=pc+4 (64-bit wrap, no carry out).
//  IDLE: redirect -> pc<=redirect_pc; still -> REQ.
//  Misaligned target: any pc update with pc[1:0]!=0 goes to FULL instead of REQ with
//   f_exc=1, f_instr=0, f_pc=target; no bus request issued. Accepted or redirected as in
//   FULL. Alignment is checked on the new pc value on entry to REQ.
//  Latency: data_ok in cycle N -> f_valid in N+1; f_ready in N+1 -> next ireq in N+2.
//  Max throughput: one instruction per 2 cycles with zero-latency bus.
//  Request never withdrawn: once ireq_valid rises, addr held until data_ok (DROP exists
//   for this). Reset mid-transaction abandons the request; the bus is reset together.
//  f_valid is registered; no combinational path from iresp_* or f_ready to f_valid/f_pc.
// STRUCTURE
//  fetch_state_t enum {IDLE,REQ,DROP,FULL} goes in package pipes; RESET_PC default in
//  package common alongside u64. Single module; the next-pc/alignment mux may be split into
//  sub-module fetch_pcgen (pc, redirect -> pc_nxt, misaligned), purely combinational.
// TESTING
//  1 release resetn, bus data_ok 2 cycles after req -> ireq_addr 8000_0000, then f_valid,
//    f_pc=8000_0000; f_ready=1 -> next ireq_addr 8000_0004.
//  2 f_ready=0 for 5 cycles in FULL -> f_valid, f_instr, f_pc stable; no ireq_valid.
//  3 redirect to 8000_0100 while REQ outstanding -> ireq_addr held until data_ok, data
//    dropped (f_valid=0), next ireq_addr 8000_0100.
//  4 redirect 8000_0200 same cycle as data_ok -> no f_valid; next ireq_addr 8000_0200.
//  5 redirect 8000_0002 -> f_valid=1, f_exc=1, f_instr=0, f_pc=8000_0002, no bus request.
//  6 assert resetn=0 mid-DROP -> outputs zero immediately; restart fetch at 8000_0000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  fetch_ctrl_pkg : shared types for the fetch-stage sequencer
//  Revision 1.0
// ============================================================================
package fetch_ctrl_pkg;

  typedef logic [63:0] u64;

  localparam int unsigned ILEN             = 32;
  localparam u64          RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  function automatic logic is_misaligned(input u64 addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  fetch_ctrl_if : instruction bus, redirect and decode handshake bundle
//  Revision 1.0
// ============================================================================
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = ILEN
) ();

  logic               ireq_valid;
  u64                 ireq_addr;
  logic               iresp_data_ok;
  logic [INSTR_W-1:0] iresp_data;
  logic               redirect_valid;
  u64                 redirect_pc;
  logic               f_valid;
  logic               f_ready;
  logic [INSTR_W-1:0] f_instr;
  u64                 f_pc;
  logic               f_exc;

  modport master (
    output ireq_valid, ireq_addr, f_valid, f_instr, f_pc, f_exc,
    input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, f_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr, f_valid, f_instr, f_pc, f_exc,
    output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, f_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_pcgen.sv
`default_nettype none
// ============================================================================
//  fetch_ctrl_pcgen : next-PC select (redirect > sequential advance > hold)
//  Revision 1.0
// ============================================================================
module fetch_ctrl_pcgen
  import fetch_ctrl_pkg::*;
(
  input  u64   pc_i,
  input  logic redirect_valid_i,
  input  u64   redirect_pc_i,
  input  logic advance_i,
  output u64   pc_d_o,
  output logic misaligned_o
);

  always_comb begin
    pc_d_o = pc_i;
    if (redirect_valid_i) begin
      pc_d_o = redirect_pc_i;
    end else if (advance_i) begin
      pc_d_o = pc_i + 64'd4;
    end
  end

  assign misaligned_o = is_misaligned(pc_d_o);

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  fetch_ctrl : fetch-stage sequencer, one outstanding ibus request,
//               redirect handling and registered hand-off to decode
//  Revision 1.0
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter u64          RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned INSTR_W  = ILEN
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_ctrl_if.master  fc
);

  fetch_state_t       state_q;
  u64                 pc_q;
  u64                 drop_addr_q;
  logic               f_valid_q;
  logic [INSTR_W-1:0] f_instr_q;
  u64                 f_pc_q;
  logic               f_exc_q;

  u64   pc_d;
  logic pc_d_mis;
  logic advance;
  logic restart;

  assign advance = (state_q == FULL) && fc.f_ready && !fc.redirect_valid;

  // Every path that would (re)issue a request funnels through here so the
  // alignment check on the new PC is applied uniformly.
  assign restart = (state_q == IDLE)
                || ((state_q == REQ)  && fc.redirect_valid && fc.iresp_data_ok)
                || ((state_q == DROP) && fc.iresp_data_ok)
                || ((state_q == FULL) && (fc.redirect_valid || fc.f_ready));

  fetch_ctrl_pcgen u_pcgen (
    .pc_i             (pc_q),
    .redirect_valid_i (fc.redirect_valid),
    .redirect_pc_i    (fc.redirect_pc),
    .advance_i        (advance),
    .pc_d_o           (pc_d),
    .misaligned_o     (pc_d_mis)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      f_valid_q   <= 1'b0;
      f_instr_q   <= '0;
      f_pc_q      <= '0;
      f_exc_q     <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (restart) begin
        if (pc_d_mis) begin
          state_q   <= FULL;
          f_valid_q <= 1'b1;
          f_exc_q   <= 1'b1;
          f_instr_q <= '0;
          f_pc_q    <= pc_d;
        end else begin
          state_q   <= REQ;
          f_valid_q <= 1'b0;
          f_exc_q   <= 1'b0;
        end
      end else if (state_q == REQ) begin
        if (fc.iresp_data_ok) begin
          state_q   <= FULL;
          f_valid_q <= 1'b1;
          f_instr_q <= fc.iresp_data;
          f_pc_q    <= pc_q;
          f_exc_q   <= 1'b0;
        end else if (fc.redirect_valid) begin
          // Request already on the bus must run to completion at its old address.
          state_q     <= DROP;
          drop_addr_q <= pc_q;
        end
      end
    end
  end

  assign fc.ireq_valid = (state_q == REQ) || (state_q == DROP);
  assign fc.ireq_addr  = (state_q == DROP) ? drop_addr_q : pc_q;
  assign fc.f_valid    = f_valid_q;
  assign fc.f_instr    = f_instr_q;
  assign fc.f_pc       = f_pc_q;
  assign fc.f_exc      = f_exc_q;

endmodule
`default_nettype wire
